// File: rtl/ontransit_req_gen_pkg.sv
// Shared definitions for the on-transit request generator: state encoding and default timeout.
package ontransit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 200;

endpackage

// File: rtl/ontransit_req_gen_if.sv
// Request/grant/stop handshake plus the command/status signals of the request generator.
interface ontransit_req_gen_if #(
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             g;
    logic             s;
    logic             do_req;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] beats;

    modport master (
        input  start, len, g, s,
        output do_req, busy, done, err, beats
    );

    modport slave (
        output start, len, g, s,
        input  do_req, busy, done, err, beats
    );
endinterface

// File: rtl/ontransit_req_gen_timer.sv
// Clear/increment wait counter; term flags the last allowed cycle (TIMEOUT-1).
module ontransit_timer #(
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);
    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + TO_W'(1);
        end
    end

    assign term = (count == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/ontransit_req_gen.sv
// Initiator for the do/g/s burst handshake; every output is a register loaded on the FSM transition.
module ontransit_req_gen
    import ontransit_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    ontransit_req_gen_if.master bus
);
    state_t           state, state_nxt;
    logic             do_r, do_nxt;
    logic             busy_r, busy_nxt;
    logic             done_r, done_nxt;
    logic             err_r, err_nxt;
    logic [LEN_W-1:0] beats_r, beats_nxt;
    logic [LEN_W-1:0] rem, rem_nxt;
    logic             tmr_clr, tmr_inc, tmr_term;
    logic             last_beat;

    assign last_beat = (rem == LEN_W'(1));

    ontransit_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .inc  (tmr_inc),
        .term (tmr_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            do_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            beats_r <= '0;
            rem     <= '0;
        end else begin
            state   <= state_nxt;
            do_r    <= do_nxt;
            busy_r  <= busy_nxt;
            done_r  <= done_nxt;
            err_r   <= err_nxt;
            beats_r <= beats_nxt;
            rem     <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start && bus.len != '0) state_nxt = REQ;
            end
            REQ: begin
                if (bus.s)         state_nxt = IDLE;
                else if (bus.g)    state_nxt = last_beat ? RELEASE : XFER;
                else if (tmr_term) state_nxt = IDLE;
            end
            XFER: begin
                if (bus.s)      state_nxt = IDLE;
                else if (bus.g) state_nxt = last_beat ? RELEASE : XFER;
                else            state_nxt = REQ;
            end
            RELEASE: begin
                if (bus.s || tmr_term) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transition actions: next register values, qualified by state and the same input priority.
    always_comb begin
        do_nxt    = do_r;
        busy_nxt  = busy_r;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        beats_nxt = beats_r;
        rem_nxt   = rem;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        case (state)
            IDLE: begin
                tmr_clr = 1'b1;
                if (bus.start) begin
                    beats_nxt = '0;
                    if (bus.len != '0) begin
                        do_nxt   = 1'b1;
                        busy_nxt = 1'b1;
                        rem_nxt  = bus.len;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            REQ, XFER: begin
                if (bus.s) begin
                    do_nxt   = 1'b0;
                    busy_nxt = 1'b0;
                    err_nxt  = 1'b1;
                    tmr_clr  = 1'b1;
                end else if (bus.g) begin
                    beats_nxt = beats_r + LEN_W'(1);
                    rem_nxt   = rem - LEN_W'(1);
                    tmr_clr   = 1'b1;
                    if (last_beat) do_nxt = 1'b0;
                end else if (state == XFER) begin
                    tmr_clr = 1'b1;
                end else if (tmr_term) begin
                    do_nxt   = 1'b0;
                    busy_nxt = 1'b0;
                    err_nxt  = 1'b1;
                    tmr_clr  = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            RELEASE: begin
                if (bus.s) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                    tmr_clr  = 1'b1;
                end else if (tmr_term) begin
                    busy_nxt = 1'b0;
                    err_nxt  = 1'b1;
                    tmr_clr  = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: tmr_clr = 1'b1;
        endcase
    end

    assign bus.do_req = do_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.beats  = beats_r;
endmodule
